// File: rtl/ex_reg.sv
// EX/MEM pipeline register: captures the ALU result and ID control bundle, and turns ALU overflow into an exception.
// Optional: define ALU_OF_TRAP_EN to make alu_of raise exception code 3 (OVERFLOW); otherwise alu_of is ignored.
module ex_reg (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] alu_out,
  input  logic        alu_of,
  input  logic [29:0] id_pc,
  input  logic        id_en,
  input  logic [1:0]  id_mem_op,
  input  logic [31:0] id_mem_wr_data,
  input  logic [4:0]  id_dst_addr,
  input  logic        id_gpr_we_,
  input  logic [2:0]  id_exp_code,
  output logic [29:0] ex_pc,
  output logic        ex_en,
  output logic [1:0]  ex_mem_op,
  output logic [31:0] ex_mem_wr_data,
  output logic [4:0]  ex_dst_addr,
  output logic        ex_gpr_we_,
  output logic [2:0]  ex_exp_code,
  output logic [31:0] ex_out,
  output logic        ex_load_hzd
);

  localparam logic [1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [2:0] EXP_NONE     = 3'd0;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  logic of_trap;

`ifdef ALU_OF_TRAP_EN
  assign of_trap = alu_of;
`else
  logic unused_alu_of;
  assign unused_alu_of = alu_of;
  assign of_trap       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_) begin
      ex_pc          <= '0;
      ex_en          <= 1'b0;
      ex_mem_op      <= MEM_OP_NOP;
      ex_mem_wr_data <= '0;
      ex_dst_addr    <= '0;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= EXP_NONE;
      ex_out         <= '0;
    end else if (flush) begin
      // Only control is killed; data fields hold their last value.
      ex_en       <= 1'b0;
      ex_mem_op   <= MEM_OP_NOP;
      ex_gpr_we_  <= 1'b1;
      ex_exp_code <= EXP_NONE;
    end else if (!stall) begin
      ex_pc          <= id_pc;
      ex_mem_wr_data <= id_mem_wr_data;
      ex_dst_addr    <= id_dst_addr;
      ex_out         <= alu_out;
      if (!id_en) begin
        ex_en       <= 1'b0;
        ex_mem_op   <= MEM_OP_NOP;
        ex_gpr_we_  <= 1'b1;
        ex_exp_code <= EXP_NONE;
      end else begin
        ex_en <= 1'b1;
        // An upstream exception outranks overflow; either one suppresses all side effects.
        if (id_exp_code != EXP_NONE) begin
          ex_exp_code <= id_exp_code;
          ex_gpr_we_  <= 1'b1;
          ex_mem_op   <= MEM_OP_NOP;
        end else if (of_trap) begin
          ex_exp_code <= EXP_OVERFLOW;
          ex_gpr_we_  <= 1'b1;
          ex_mem_op   <= MEM_OP_NOP;
        end else begin
          ex_exp_code <= EXP_NONE;
          ex_gpr_we_  <= id_gpr_we_;
          ex_mem_op   <= id_mem_op;
        end
      end
    end
  end

  assign ex_load_hzd = ex_en & (ex_mem_op == MEM_OP_LOAD) & ~ex_gpr_we_;

endmodule

// File: tb/tb_ex_reg.sv
// Self-checking bench for ex_reg: directed scenarios plus randomized traffic against a behavioural model.
module tb_ex_reg;

`ifdef ALU_OF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_, stall, flush, alu_of, id_en, id_gpr_we_;
  logic [31:0] alu_out, id_mem_wr_data;
  logic [29:0] id_pc;
  logic [1:0]  id_mem_op;
  logic [4:0]  id_dst_addr;
  logic [2:0]  id_exp_code;
  logic [29:0] ex_pc;
  logic        ex_en, ex_gpr_we_, ex_load_hzd;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [29:0] m_pc;
  logic        m_en, m_we_;
  logic [1:0]  m_mem;
  logic [31:0] m_wd, m_out;
  logic [4:0]  m_dst;
  logic [2:0]  m_exp;

  ex_reg dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush),
    .alu_out(alu_out), .alu_of(alu_of), .id_pc(id_pc), .id_en(id_en),
    .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data), .id_dst_addr(id_dst_addr),
    .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
    .ex_out(ex_out), .ex_load_hzd(ex_load_hzd)
  );

  always #5 clk = ~clk;

  // Next-state from the rules: the slot's exception code is decided first, then
  // anything that is not a clean valid instruction loses its side effects.
  task automatic model_edge();
    logic [2:0] code;
    logic       quiet;
    if (!reset_) begin
      m_pc = 0; m_en = 0; m_mem = 0; m_wd = 0; m_dst = 0; m_we_ = 1; m_exp = 0; m_out = 0;
    end else if (flush) begin
      m_en = 0; m_mem = 0; m_we_ = 1; m_exp = 0;
    end else if (!stall) begin
      m_pc = id_pc; m_wd = id_mem_wr_data; m_dst = id_dst_addr; m_out = alu_out;
      if (!id_en)                code = 3'd0;
      else if (id_exp_code != 0) code = id_exp_code;
      else if (TRAP && alu_of)   code = 3'd3;
      else                       code = 3'd0;
      quiet = !id_en || (code != 0);
      m_en  = id_en;
      m_exp = code;
      m_we_ = quiet ? 1'b1 : id_gpr_we_;
      m_mem = quiet ? 2'd0 : id_mem_op;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset_ = 1; stall = 0; flush = 0; alu_out = 0; alu_of = 0; id_pc = 0; id_en = 0;
    id_mem_op = 0; id_mem_wr_data = 0; id_dst_addr = 0; id_gpr_we_ = 1; id_exp_code = 0;
  endtask

  task automatic test_reset();
    reset_ = 0; stall = 1; flush = 1; alu_out = '1; alu_of = 1; id_pc = '1; id_en = 1;
    id_mem_op = '1; id_mem_wr_data = '1; id_dst_addr = '1; id_gpr_we_ = 1; id_exp_code = '1;
    tick();
    tick();
    checks++;
    if ({ex_pc, ex_en, ex_mem_op, ex_mem_wr_data, ex_dst_addr, ex_exp_code, ex_out} !== '0) begin
      errors++;
      $display("FAIL reset_fields got pc=%h en=%b op=%h wd=%h dst=%h exp=%h out=%h exp all 0",
               ex_pc, ex_en, ex_mem_op, ex_mem_wr_data, ex_dst_addr, ex_exp_code, ex_out);
    end
    checks++;
    if (ex_gpr_we_ !== 1'b1) begin errors++; $display("FAIL reset_we got %b exp 1", ex_gpr_we_); end
    checks++;
    if (ex_load_hzd !== 1'b0) begin errors++; $display("FAIL reset_hzd got %b exp 0", ex_load_hzd); end
  endtask

  task automatic test_capture();
    set_idle();
    id_en = 1; alu_out = 32'h1234_5678; id_dst_addr = 5'd7; id_gpr_we_ = 0; id_mem_op = 0;
    id_pc = 30'h0000_0100; id_mem_wr_data = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (ex_out !== 32'h1234_5678) begin errors++; $display("FAIL capture_out got %h exp 12345678", ex_out); end
    checks++;
    if ({ex_dst_addr, ex_gpr_we_, ex_en} !== {5'd7, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL capture_ctrl got dst=%0d we_=%b en=%b exp dst=7 we_=0 en=1", ex_dst_addr, ex_gpr_we_, ex_en);
    end
    checks++;
    if ({ex_pc, ex_mem_wr_data, ex_exp_code} !== {30'h0000_0100, 32'hDEAD_BEEF, 3'd0}) begin
      errors++;
      $display("FAIL capture_data got pc=%h wd=%h exp=%h", ex_pc, ex_mem_wr_data, ex_exp_code);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_out = $urandom; id_dst_addr = 5'($urandom); id_pc = 30'($urandom); id_en = 0;
      tick();
      checks++;
      if ({ex_out, ex_en, ex_dst_addr} !== {32'h1234_5678, 1'b1, 5'd7}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got out=%h en=%b dst=%0d exp out=12345678 en=1 dst=7", i, ex_out, ex_en, ex_dst_addr);
      end
    end
    flush = 1;
    tick();
    checks++;
    if ({ex_en, ex_gpr_we_, ex_mem_op, ex_exp_code} !== {1'b0, 1'b1, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL stall_flush_ctrl got en=%b we_=%b op=%h exp=%h exp en=0 we_=1", ex_en, ex_gpr_we_, ex_mem_op, ex_exp_code);
    end
    checks++;
    if ({ex_out, ex_dst_addr} !== {32'h1234_5678, 5'd7}) begin
      errors++;
      $display("FAIL stall_flush_data got out=%h dst=%0d exp out=12345678 dst=7", ex_out, ex_dst_addr);
    end
  endtask

  task automatic test_overflow();
    set_idle();
    id_en = 1; alu_out = 32'h8000_0000; alu_of = 1; id_gpr_we_ = 0; id_mem_op = 2'd2;
    tick();
    checks++;
    if (TRAP) begin
      if ({ex_exp_code, ex_gpr_we_, ex_mem_op} !== {3'd3, 1'b1, 2'd0}) begin
        errors++;
        $display("FAIL overflow_trap got exp=%0d we_=%b op=%0d exp exp=3 we_=1 op=0", ex_exp_code, ex_gpr_we_, ex_mem_op);
      end
    end else begin
      if ({ex_exp_code, ex_gpr_we_, ex_mem_op} !== {3'd0, 1'b0, 2'd2}) begin
        errors++;
        $display("FAIL overflow_ignored got exp=%0d we_=%b op=%0d exp exp=0 we_=0 op=2", ex_exp_code, ex_gpr_we_, ex_mem_op);
      end
    end
    checks++;
    if (ex_out !== 32'h8000_0000) begin errors++; $display("FAIL overflow_out got %h exp 80000000", ex_out); end
  endtask

  task automatic test_exp_priority();
    set_idle();
    id_en = 1; id_exp_code = 3'd1; alu_of = 1; id_gpr_we_ = 0; id_mem_op = 2'd1;
    tick();
    checks++;
    if ({ex_exp_code, ex_gpr_we_, ex_mem_op} !== {3'd1, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL exp_priority got exp=%0d we_=%b op=%0d exp exp=1 we_=1 op=0", ex_exp_code, ex_gpr_we_, ex_mem_op);
    end
  endtask

  task automatic test_load_hzd();
    set_idle();
    id_en = 1; id_mem_op = 2'd1; id_gpr_we_ = 0; id_dst_addr = 5'd3;
    tick();
    checks++;
    if (ex_load_hzd !== 1'b1) begin errors++; $display("FAIL load_hzd_set got %b exp 1", ex_load_hzd); end
    set_idle();
    flush = 1;
    tick();
    checks++;
    if (ex_load_hzd !== 1'b0) begin errors++; $display("FAIL load_hzd_flush got %b exp 0", ex_load_hzd); end
    set_idle();
    id_en = 1; id_mem_op = 2'd1; id_gpr_we_ = 1;
    tick();
    checks++;
    if (ex_load_hzd !== 1'b0) begin errors++; $display("FAIL load_hzd_no_we got %b exp 0", ex_load_hzd); end
  endtask

  task automatic test_back_to_back();
    logic [105:0] act, expv;
    for (int i = 0; i < 400; i++) begin
      reset_         = ($urandom_range(0, 39) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 7) == 0);
      alu_out        = $urandom;
      alu_of         = ($urandom_range(0, 3) == 0);
      id_pc          = 30'($urandom);
      id_en          = ($urandom_range(0, 3) != 0);
      id_mem_op      = 2'($urandom_range(0, 2));
      id_mem_wr_data = $urandom;
      id_dst_addr    = 5'($urandom);
      id_gpr_we_     = 1'($urandom);
      id_exp_code    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      tick();
      act  = {ex_pc, ex_en, ex_mem_op, ex_mem_wr_data, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out};
      expv = {m_pc, m_en, m_mem, m_wd, m_dst, m_we_, m_exp, m_out};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL random_regs[%0d] got %h exp %h", i, act, expv);
      end
      checks++;
      if (ex_load_hzd !== (m_en && m_mem == 2'd1 && !m_we_)) begin
        errors++;
        $display("FAIL random_hzd[%0d] got %b exp %b", i, ex_load_hzd, (m_en && m_mem == 2'd1 && !m_we_));
      end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    set_idle();
    test_capture();
    test_stall();
    test_overflow();
    test_exp_priority();
    test_load_hzd();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
